bist_controller: RTL and testbench
==================================

Name: bist_controller

Overview:
- On-chip BIST sequencer for the TRCUTwithLFSR scan-BIST core.
- Upstream role: generates the SE shift/capture waveform that the core consumes.
- Downstream role: compacts the core's serial SO stream into a signature register (SISR), compares it against a golden signature, and reports DONE/PASS.
- Replaces testbench-driven SE sequencing and raw SO collection with a self-contained pass/fail test.

Parameters:
- CHAIN_LEN, 4, scan-chain length; shift cycles per vector.
- NUM_VECTORS, 32, pseudo-random vectors applied per run.
- SIG_W, 16, signature register width.
- SIG_POLY, 16'h1021, SISR feedback polynomial; bit i set means tap at bit i.
- SIG_SEED, 16'h0000, signature value loaded at reset and at START.
- GOLDEN_SIG, 16'h0000, expected final signature.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset; also shared with TRCUTwithLFSR.
- START  in  1  level; sampled only in IDLE and DONE_ST; starts a run.
- SO  in  1  scan-out from TRCUTwithLFSR.
- SE  out  1  scan enable to TRCUTwithLFSR; decoded from registered state only.
- BUSY  out  1  high in every state except IDLE and DONE_ST.
- DONE  out  1  high in DONE_ST.
- PASS  out  1  valid only while DONE=1; signature == GOLDEN_SIG.
- SIGNATURE  out  SIG_W  present only with BIST_SIG_OUT_EN.

Behaviour:
- Reset values: state=IDLE, SE=0, BUSY=0, DONE=0, PASS=0, sig=SIG_SEED, bit_cnt=0, vec_cnt=0.
- States: IDLE, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE_ST.
- IDLE → SHIFT when START=1 at an edge (edge 0). START in DONE_ST behaves the same: clears DONE/PASS, reloads SIG_SEED and both counters.
- SHIFT: SE=1 for CHAIN_LEN cycles; bit_cnt counts 0..CHAIN_LEN-1; on the last count go to CAPTURE.
- CAPTURE: SE=0 for exactly 1 cycle; vec_cnt++.
  - If vec_cnt was NUM_VECTORS-1, go to UNLOAD; otherwise go to SHIFT.
- UNLOAD: SE=1 for CHAIN_LEN cycles; flushes the last response. Then go to COMPARE.
- COMPARE: 1 cycle; PASS register <= (sig == GOLDEN_SIG). Then go to DONE_ST.
- DONE_ST: holds until RST or START.
- Compaction:
  - On every SE=1 edge in SHIFT with vec_cnt>0, and every UNLOAD edge: sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : 0) ^ {{SIG_W-1{1'b0}},SO}.
  - The SHIFT edges of vector 0 are not compacted; the chain holds reset contents.
  - Total compacted bits = NUM_VECTORS*CHAIN_LEN (128 at defaults).
- Timeline at defaults: vector phases cover edges 1..160; UNLOAD edges 161..164; COMPARE ends at edge 165; DONE=1 after edge 165.
- START while BUSY is ignored and does not restart the run.
- RST mid-run returns immediately to reset values; no partial result is retained.
- Counter widths are $clog2 of their limits with a minimum of 1. Parameters CHAIN_LEN=1 and NUM_VECTORS=1 must work.

Optional Feature:
- Macro: BIST_SIG_OUT_EN.
- Defined: SIGNATURE port exists and continuously mirrors sig. This gives a golden-value extraction path for characterisation runs.
- Undefined: the port is absent; only PASS and DONE are visible. Internal behaviour is identical.

Decomposition:
- Package bist_pkg holds:
  - the state enum (6 states, 3 bits);
  - default CHAIN_LEN, NUM_VECTORS, SIG_W, SIG_POLY;
  - a sisr_next(sig, bit, poly) function shared with the bench reference model.
- Sub-module bist_sisr: SIG_W-bit signature register with enable, load-seed and serial input.
- The FSM and counters stay in bist_controller.

Test Plan:
- SO tied 0, GOLDEN_SIG=0: START pulse → SE high for 4 cycles, low for 1, repeated 32 times, then high for 4. DONE rises after edge 165, PASS=1, SIGNATURE=16'h0000.
- SO=1 only at edge 164 (last unload bit) → SIGNATURE=16'h0001. With GOLDEN_SIG=0, PASS=0.
- SO=1 only at edge 161 (first unload bit) → SIGNATURE=16'h0008. SO=1 only during edges 1..4 → SIGNATURE=16'h0000, confirming vector 0 is discarded.
- Random SO stream checked against a bist_pkg::sisr_next reference model → SIGNATURE matches the model. Setting GOLDEN_SIG to the model value gives PASS=1; flipping any one SO bit gives PASS=0.
- RST asserted at edge 80 mid-SHIFT → SE, BUSY, DONE drop to 0 asynchronously. A new START re-runs the full 165-edge sequence with SIG_SEED reloaded.
- START held high throughout → no restart while BUSY. In DONE_ST the next START edge clears DONE and begins a new run. CHAIN_LEN=1 with NUM_VECTORS=1 gives DONE after edge 4.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types, defaults and the SISR step function for the scan-BIST controller.
package bist_pkg;

  localparam int unsigned DEF_CHAIN_LEN   = 4;
  localparam int unsigned DEF_NUM_VECTORS = 32;
  localparam int unsigned DEF_SIG_W       = 16;
  localparam logic [DEF_SIG_W-1:0] DEF_SIG_POLY = 16'h1021;

  // Sequencer states; DONE_ST holds the verdict until the next START or RST
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_UNLOAD  = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } bist_state_e;

  // One SISR step: shift left, fold the MSB back through the taps, xor in the serial bit
  function automatic logic [DEF_SIG_W-1:0] sisr_next(
    input logic [DEF_SIG_W-1:0] sig,
    input logic                 so_bit,
    input logic [DEF_SIG_W-1:0] poly
  );
    sisr_next = {sig[DEF_SIG_W-2:0], 1'b0}
              ^ (sig[DEF_SIG_W-1] ? poly : '0)
              ^ {{(DEF_SIG_W-1){1'b0}}, so_bit};
  endfunction

endpackage

// File: rtl/bist_sisr.sv
// Serial-input signature register: compacts one SO bit per enabled edge.
module bist_sisr
  import bist_pkg::*;
#(
  parameter int unsigned      SIG_W    = DEF_SIG_W,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(DEF_SIG_POLY),
  parameter logic [SIG_W-1:0] SIG_SEED = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic             so,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_next_c;

  // Next signature value for the current serial bit
  always_comb begin
    sig_next_c = {sig[SIG_W-2:0], 1'b0}
               ^ (sig[SIG_W-1] ? SIG_POLY : '0)
               ^ SIG_W'(so);
  end

  // Seed on reset or run start, otherwise compact when enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= SIG_SEED;
    end else if (load) begin
      sig <= SIG_SEED;
    end else if (en) begin
      sig <= sig_next_c;
    end
  end

endmodule

// File: rtl/bist_controller.sv
// Scan-BIST sequencer: drives SE shift/capture, compacts SO, reports DONE/PASS.
// Optional macro BIST_SIG_OUT_EN exposes the live signature on SIGNATURE.
module bist_controller
  import bist_pkg::*;
#(
  parameter int unsigned      CHAIN_LEN   = DEF_CHAIN_LEN,
  parameter int unsigned      NUM_VECTORS = DEF_NUM_VECTORS,
  parameter int unsigned      SIG_W       = DEF_SIG_W,
  parameter logic [SIG_W-1:0] SIG_POLY    = SIG_W'(DEF_SIG_POLY),
  parameter logic [SIG_W-1:0] SIG_SEED    = '0,
  parameter logic [SIG_W-1:0] GOLDEN_SIG  = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SO,
  output logic             SE,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS
`ifdef BIST_SIG_OUT_EN
  ,
  output logic [SIG_W-1:0] SIGNATURE
`endif
);

  localparam int unsigned BIT_W = (CHAIN_LEN > 1)   ? $clog2(CHAIN_LEN)   : 1;
  localparam int unsigned VEC_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LEN - 1);
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VECTORS - 1);

  bist_state_e      state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [VEC_W-1:0] vec_cnt_q, vec_cnt_d;
  logic             pass_d;
  logic             se_d, busy_d, done_d;
  logic             sig_load_c, sig_en_c;
  logic [SIG_W-1:0] sig;

  // State, counters and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      vec_cnt_q <= '0;
      SE        <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      vec_cnt_q <= vec_cnt_d;
      SE        <= se_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
      PASS      <= pass_d;
    end
  end

  // Next state, counter updates, SISR control and output decode
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    vec_cnt_d  = vec_cnt_q;
    pass_d     = PASS;
    sig_load_c = 1'b0;
    sig_en_c   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_d    = ST_SHIFT;
          bit_cnt_d  = '0;
          vec_cnt_d  = '0;
          pass_d     = 1'b0;
          sig_load_c = 1'b1;
        end
      end
      ST_SHIFT: begin
        // vector 0 shifts out reset contents of the chain, so skip it
        sig_en_c = (vec_cnt_q != '0);
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          state_d   = ST_CAPTURE;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        vec_cnt_d = vec_cnt_q + 1'b1;
        state_d   = (vec_cnt_q == VEC_LAST) ? ST_UNLOAD : ST_SHIFT;
      end
      ST_UNLOAD: begin
        sig_en_c = 1'b1;
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          state_d   = ST_COMPARE;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_COMPARE: begin
        pass_d  = (sig == GOLDEN_SIG);
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    se_d   = (state_d == ST_SHIFT) || (state_d == ST_UNLOAD);
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  bist_sisr #(
    .SIG_W    (SIG_W),
    .SIG_POLY (SIG_POLY),
    .SIG_SEED (SIG_SEED)
  ) u_sisr (
    .clk  (CLK),
    .rst  (RST),
    .load (sig_load_c),
    .en   (sig_en_c),
    .so   (SO),
    .sig  (sig)
  );

`ifdef BIST_SIG_OUT_EN
  // Live signature for golden-value extraction
  assign SIGNATURE = sig;
`endif

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: four default-config instances with different golden
// signatures share one stimulus; a small CHAIN_LEN=1/NUM_VECTORS=1 instance runs alone.
module tb_bist_controller;

  localparam int CL    = 4;
  localparam int NV    = 32;
  localparam int P     = CL + 1;
  localparam int TOTAL = NV * P + CL + 1;
  localparam logic [15:0] POLY = 16'h1021;
  localparam logic [15:0] SEED = 16'h0000;

  // Signature model as polynomial arithmetic: s*x + b mod (x^16 + POLY)
  function automatic logic [15:0] ref_step(input logic [15:0] s, input logic b);
    logic [16:0] t;
    t = {s, b};
    if (t[16]) t = t ^ {1'b1, POLY};
    return t[15:0];
  endfunction

  // Whether the SO value present at run edge e gets folded into the signature
  function automatic bit compacted(input int e);
    int v;
    int pos;
    if (e >= 1 && e <= NV * P) begin
      v   = (e - 1) / P;
      pos = (e - 1) % P;
      return (pos < CL) && (v >= 1);
    end
    return (e > NV * P) && (e <= NV * P + CL);
  endfunction

  function automatic logic rand_bit(input int e);
    return ((e * 13 + (e * e) / 7) % 5) < 2;
  endfunction

  function automatic logic [15:0] rand_sig();
    logic [15:0] s;
    s = SEED;
    for (int e = 1; e <= TOTAL; e++)
      if (compacted(e)) s = ref_step(s, rand_bit(e));
    return s;
  endfunction

  localparam logic [15:0] G_RAND = rand_sig();

  function automatic logic [15:0] gold_of(input int g);
    case (g)
      0:       return 16'h0000;
      1:       return 16'h0001;
      2:       return 16'h0008;
      default: return G_RAND;
    endcase
  endfunction

  function automatic logic so_val(input int mode, input int e);
    case (mode)
      0:       return 1'b0;
      1:       return e == 164;
      2:       return e == 161;
      3:       return (e >= 1) && (e <= 4);
      4:       return rand_bit(e);
      5:       return rand_bit(e) ^ (e == 97);
      default: return rand_bit(e) ^ (e == 2);
    endcase
  endfunction

  logic CLK, RST, START, SO, start_s;
  logic [3:0] se_v, busy_v, done_v, pass_v;
  logic se_s, busy_s, done_s, pass_s;
`ifdef BIST_SIG_OUT_EN
  logic [15:0] sig_v [4];
  logic [15:0] sig_s;
`endif

  for (genvar g = 0; g < 4; g++) begin : g_dut
    bist_controller #(
      .CHAIN_LEN   (CL),
      .NUM_VECTORS (NV),
      .SIG_W       (16),
      .SIG_POLY    (POLY),
      .SIG_SEED    (SEED),
      .GOLDEN_SIG  (gold_of(g))
    ) u_dut (
      .CLK   (CLK),
      .RST   (RST),
      .START (START),
      .SO    (SO),
      .SE    (se_v[g]),
      .BUSY  (busy_v[g]),
      .DONE  (done_v[g]),
      .PASS  (pass_v[g])
`ifdef BIST_SIG_OUT_EN
      ,
      .SIGNATURE (sig_v[g])
`endif
    );
  end

  bist_controller #(
    .CHAIN_LEN   (1),
    .NUM_VECTORS (1),
    .SIG_W       (16),
    .SIG_POLY    (POLY),
    .SIG_SEED    (SEED),
    .GOLDEN_SIG  (16'h0000)
  ) u_small (
    .CLK   (CLK),
    .RST   (RST),
    .START (start_s),
    .SO    (1'b0),
    .SE    (se_s),
    .BUSY  (busy_s),
    .DONE  (done_s),
    .PASS  (pass_s)
`ifdef BIST_SIG_OUT_EN
    ,
    .SIGNATURE (sig_s)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_cmp;
  int n_err;

  // Model state: whether a run is active, edges since the START edge, finished, signature
  bit          m_active;
  bit          m_done;
  int          m_e;
  logic [15:0] m_sig;

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_e      = 0;
    m_sig    = SEED;
  endfunction

  // Advance the model by one rising edge using the inputs present at that edge
  function automatic void model_step();
    if (RST) begin
      model_reset();
    end else if (!m_active || m_done) begin
      if (START) begin
        m_active = 1'b1;
        m_done   = 1'b0;
        m_e      = 0;
        m_sig    = SEED;
      end
    end else begin
      m_e++;
      if (compacted(m_e)) m_sig = ref_step(m_sig, SO);
      if (m_e == TOTAL) m_done = 1'b1;
    end
  endfunction

  function automatic void compare_outputs();
    logic e_se, e_busy, e_done;
    e_se = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    if (!RST && m_active) begin
      if (m_done) begin
        e_done = 1'b1;
      end else begin
        e_busy = 1'b1;
        if (m_e < NV * P) e_se = (m_e % P) != CL;
        else              e_se = m_e < NV * P + CL;
      end
    end
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("se[%0d]", g),   16'(se_v[g]),   16'(e_se));
      chk($sformatf("busy[%0d]", g), 16'(busy_v[g]), 16'(e_busy));
      chk($sformatf("done[%0d]", g), 16'(done_v[g]), 16'(e_done));
      if (e_done) chk($sformatf("pass[%0d]", g), 16'(pass_v[g]), 16'(m_sig == gold_of(g)));
`ifdef BIST_SIG_OUT_EN
      chk($sformatf("signature[%0d]", g), sig_v[g], m_sig);
`endif
    end
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    compare_outputs();
    @(negedge CLK);
  endtask

  task automatic run_scenario(input int mode);
    START = 1'b1;
    SO    = 1'b0;
    tick();
    START = 1'b0;
    for (int e = 1; e <= TOTAL + 2; e++) begin
      SO = so_val(mode, e);
      tick();
    end
    SO = 1'b0;
  endtask

  initial begin
    logic [4:0] se_tab, busy_tab, done_tab;
    n_cmp = 0;
    n_err = 0;
    model_reset();
    RST = 1'b1; START = 1'b0; SO = 1'b0; start_s = 1'b0;

    // Reset state
    tick();
    tick();
    chk("reset_done", 16'(done_v), 16'h0);
    chk("reset_small_busy", 16'(busy_s), 16'h0);
    RST = 1'b0;
    tick();

    // Model pinned against hand-computed steps and the package function
    chk("model_step_msb", ref_step(16'h8000, 1'b0), 16'h1021);
    chk("model_step_bit", ref_step(16'h0001, 1'b1), 16'h0003);
    chk("pkg_sisr_a", bist_pkg::sisr_next(16'hA5C3, 1'b1, POLY), ref_step(16'hA5C3, 1'b1));
    chk("pkg_sisr_b", bist_pkg::sisr_next(16'h7FFF, 1'b0, POLY), ref_step(16'h7FFF, 1'b0));

    // SO tied low
    run_scenario(0);
    chk("zero_sig", m_sig, 16'h0000);
    chk("zero_pass", 16'(pass_v), 16'b0001);
    // Only the last unload bit set
    run_scenario(1);
    chk("last_sig", m_sig, 16'h0001);
    chk("last_pass", 16'(pass_v), 16'b0010);
    // Only the first unload bit set
    run_scenario(2);
    chk("first_unload_sig", m_sig, 16'h0008);
    chk("first_unload_pass", 16'(pass_v), 16'b0100);
    // Vector 0 shift bits are discarded
    run_scenario(3);
    chk("vec0_sig", m_sig, 16'h0000);
    chk("vec0_pass", 16'(pass_v), 16'b0001);
    // Pseudo-random stream, then single flips at a compacted and a discarded edge
    run_scenario(4);
    chk("rand_pass", 16'(pass_v[3]), 16'h1);
    run_scenario(5);
    chk("flip_pass", 16'(pass_v[3]), 16'h0);
    run_scenario(6);
    chk("flip_vec0_pass", 16'(pass_v[3]), 16'h1);

    // Reset mid-shift drops outputs asynchronously, then a full rerun
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int e = 1; e <= 80; e++) tick();
    chk("mid_se", 16'(se_v), 16'hF);
    RST = 1'b1;
    #1;
    chk("async_se", 16'(se_v), 16'h0);
    chk("async_busy", 16'(busy_v), 16'h0);
    chk("async_done", 16'(done_v), 16'h0);
    model_reset();
    tick();
    tick();
    RST = 1'b0;
    tick();
    run_scenario(0);
    chk("rerun_done", 16'(done_v), 16'hF);
    chk("rerun_pass", 16'(pass_v), 16'b0001);

    // START held high: no restart while busy, restart from DONE_ST
    START = 1'b1;
    for (int i = 0; i < 340; i++) begin
      if (i == 250) START = 1'b0;
      if (i == 100) chk("held_busy", 16'(busy_v), 16'hF);
      tick();
    end
    chk("held_done", 16'(done_v), 16'hF);

    // Minimal configuration: DONE after edge 4
    se_tab   = 5'b00101;
    busy_tab = 5'b01111;
    done_tab = 5'b10000;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      chk($sformatf("small_se_e%0d", k),   16'(se_s),   16'(se_tab[k]));
      chk($sformatf("small_busy_e%0d", k), 16'(busy_s), 16'(busy_tab[k]));
      chk($sformatf("small_done_e%0d", k), 16'(done_s), 16'(done_tab[k]));
    end
    chk("small_pass", 16'(pass_s), 16'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
